// File: rtl/system_register_pkg.sv
// Shared types, reset values and beat-count lookup for the system table registers.
package system_register_pkg;

    localparam int unsigned BUF_WIDTH = 96;
    localparam int unsigned CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        TGT_GDTR = 2'd0,
        TGT_IDTR = 2'd1,
        TGT_LDTR = 2'd2,
        TGT_TR   = 2'd3
    } target_e;

    typedef struct packed {
        logic [31:0] base;
        logic [15:0] limit;
    } table_reg_t;

    typedef struct packed {
        logic [15:0] sel;
        logic [31:0] base;
        logic [31:0] limit;
        logic [7:0]  attr;
        logic        valid;
    } seg_reg_t;

    localparam table_reg_t GDTR_RESET = '{base: 32'h0000_0000, limit: 16'hFFFF};
    localparam table_reg_t IDTR_RESET = '{base: 32'h0000_0000, limit: 16'h03FF};
    localparam seg_reg_t   SEG_RESET  = '{sel: 16'h0000, base: 32'h0000_0000,
                                          limit: 32'h0000_FFFF, attr: 8'h00, valid: 1'b0};

    // Number of beats a load needs; a null selector collapses LDTR/TR to one beat.
    function automatic logic [CNT_WIDTH-1:0] beat_count(input target_e     tgt,
                                                         input int unsigned data_width,
                                                         input logic        null_sel);
        logic [CNT_WIDTH-1:0] n;
        if (tgt == TGT_GDTR || tgt == TGT_IDTR) begin
            n = (data_width == 16) ? CNT_WIDTH'(3) : CNT_WIDTH'(2);
        end else if (null_sel) begin
            n = CNT_WIDTH'(1);
        end else begin
            n = (data_width == 16) ? CNT_WIDTH'(5) : CNT_WIDTH'(3);
        end
        return n;
    endfunction

endpackage

// File: rtl/descriptor_unpack.sv
// Combinational split of a 64-bit segment descriptor into base, limit and attributes.
module descriptor_unpack (
    input  logic [63:0] desc,
    output logic [31:0] base_c,
    output logic [31:0] limit_c,
    output logic [7:0]  attr_c
);

    logic [19:0] raw_limit_c;
    logic        unused_c;

    always_comb begin
        base_c      = {desc[63:56], desc[39:16]};
        raw_limit_c = {desc[51:48], desc[15:0]};
        attr_c      = desc[47:40];
        // Granularity bit scales the limit to 4 KiB pages.
        limit_c     = desc[55] ? {raw_limit_c, 12'hFFF} : {12'h000, raw_limit_c};
    end

    assign unused_c = ^desc[54:52];

endmodule

// File: rtl/system_table_registers.sv
// Beat-wise loader for GDTR/IDTR/LDTR/TR; assembles a payload and commits it atomically.
module system_table_registers
    import system_register_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [1:0]            load_target,
    input  logic                  load_o16,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  load_abort,
    output logic                  load_done,
    output logic                  load_error,
    output logic [31:0]           gdtr_base,
    output logic [15:0]           gdtr_limit,
    output logic [31:0]           idtr_base,
    output logic [15:0]           idtr_limit,
    output logic [SEL_WIDTH-1:0]  ldtr_sel,
    output logic [31:0]           ldtr_base,
    output logic [31:0]           ldtr_limit,
    output logic [7:0]            ldtr_attr,
    output logic                  ldtr_valid,
    output logic [SEL_WIDTH-1:0]  tr_sel,
    output logic [31:0]           tr_base,
    output logic [31:0]           tr_limit,
    output logic [7:0]            tr_attr,
    output logic                  tr_valid
);

    localparam int unsigned MAX_BEATS = BUF_WIDTH / DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] req_q, req_d;
    target_e              tgt_q, tgt_d;
    logic                 o16_q, o16_d;
    logic [BUF_WIDTH-1:0] asm_q, asm_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 ready_q, ready_d;
    table_reg_t           gdtr_q, gdtr_d, idtr_q, idtr_d;
    seg_reg_t             ldtr_q, ldtr_d, tr_q, tr_d;

    logic                 first_c, abort_c, accept_c, null_sel_c, final_c, end_c;
    logic                 tr_null_c, ldtr_null_c, frame_err_c, o16_c;
    target_e              tgt_c;
    logic [CNT_WIDTH-1:0] req_c;
    logic [31:0]          desc_base_c, desc_limit_c;
    logic [7:0]           desc_attr_c;
    table_reg_t           table_commit_c;
    seg_reg_t             seg_commit_c;

    // First-beat fields come straight from the inputs; later beats use the latched copies.
    always_comb begin
        first_c     = (state_q == ST_IDLE);
        abort_c     = (state_q == ST_COLLECT) && load_abort;
        accept_c    = load_valid && load_ready && !abort_c;
        null_sel_c  = (load_data[15:2] == 14'd0);
        tgt_c       = first_c ? target_e'(load_target) : tgt_q;
        o16_c       = first_c ? load_o16 : o16_q;
        req_c       = first_c ? beat_count(target_e'(load_target), DATA_WIDTH, null_sel_c) : req_q;
        final_c     = (CNT_WIDTH'(cnt_q + 1'b1) == req_c);
        end_c       = accept_c && (final_c || load_last);
        tr_null_c   = first_c && (tgt_c == TGT_TR) && null_sel_c;
        ldtr_null_c = first_c && (tgt_c == TGT_LDTR) && null_sel_c;
        frame_err_c = (load_last != final_c) || tr_null_c;
    end

    // Assembly buffer: each accepted beat lands in the slot selected by the beat counter.
    always_comb begin
        asm_d = asm_q;
        if (accept_c) begin
            if (first_c) begin
                asm_d = '0;
            end
            for (int i = 0; i < int'(MAX_BEATS); i++) begin
                if (cnt_q == CNT_WIDTH'(i)) begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = load_data;
                end
            end
        end
    end

    descriptor_unpack u_descriptor_unpack (
        .desc    (asm_d[DATA_WIDTH +: 64]),
        .base_c  (desc_base_c),
        .limit_c (desc_limit_c),
        .attr_c  (desc_attr_c)
    );

    always_comb begin
        table_commit_c.limit = asm_d[15:0];
        table_commit_c.base  = asm_d[47:16];
        if (o16_c) begin
            table_commit_c.base[31:24] = 8'h00;
        end
        seg_commit_c.sel   = asm_d[15:0];
        seg_commit_c.base  = desc_base_c;
        seg_commit_c.limit = desc_limit_c;
        seg_commit_c.attr  = desc_attr_c;
        seg_commit_c.valid = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        tgt_d   = tgt_q;
        o16_d   = o16_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        gdtr_d  = gdtr_q;
        idtr_d  = idtr_q;
        ldtr_d  = ldtr_q;
        tr_d    = tr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    tgt_d   = tgt_c;
                    o16_d   = o16_c;
                    req_d   = req_c;
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (abort_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (accept_c) begin
                    cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Final or framing-terminating beat: commit everything on this edge or nothing.
        if (end_c) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            if (frame_err_c) begin
                error_d = 1'b1;
            end else begin
                done_d = 1'b1;
                unique case (tgt_c)
                    TGT_GDTR: gdtr_d = table_commit_c;
                    TGT_IDTR: idtr_d = table_commit_c;
                    TGT_LDTR: begin
                        if (ldtr_null_c) begin
                            ldtr_d.sel   = asm_d[15:0];
                            ldtr_d.valid = 1'b0;
                        end else begin
                            ldtr_d = seg_commit_c;
                        end
                    end
                    TGT_TR:   tr_d = seg_commit_c;
                    default:  gdtr_d = gdtr_q;
                endcase
            end
        end

        ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            tgt_q   <= TGT_GDTR;
            o16_q   <= 1'b0;
            asm_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
            gdtr_q  <= GDTR_RESET;
            idtr_q  <= IDTR_RESET;
            ldtr_q  <= SEG_RESET;
            tr_q    <= SEG_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            tgt_q   <= tgt_d;
            o16_q   <= o16_d;
            asm_q   <= asm_d;
            done_q  <= done_d;
            error_q <= error_d;
            ready_q <= ready_d;
            gdtr_q  <= gdtr_d;
            idtr_q  <= idtr_d;
            ldtr_q  <= ldtr_d;
            tr_q    <= tr_d;
        end
    end

    assign load_ready = ready_q;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign gdtr_base  = gdtr_q.base;
    assign gdtr_limit = gdtr_q.limit;
    assign idtr_base  = idtr_q.base;
    assign idtr_limit = idtr_q.limit;
    assign ldtr_sel   = SEL_WIDTH'(ldtr_q.sel);
    assign ldtr_base  = ldtr_q.base;
    assign ldtr_limit = ldtr_q.limit;
    assign ldtr_attr  = ldtr_q.attr;
    assign ldtr_valid = ldtr_q.valid;
    assign tr_sel     = SEL_WIDTH'(tr_q.sel);
    assign tr_base    = tr_q.base;
    assign tr_limit   = tr_q.limit;
    assign tr_attr    = tr_q.attr;
    assign tr_valid   = tr_q.valid;

endmodule

// File: tb/tb_system_table_registers.sv
// Directed bench for system_table_registers at DATA_WIDTH=32 and DATA_WIDTH=16.
module tb_system_table_registers;

    localparam logic [1:0] T_GDTR = 2'd0;
    localparam logic [1:0] T_IDTR = 2'd1;
    localparam logic [1:0] T_LDTR = 2'd2;
    localparam logic [1:0] T_TR   = 2'd3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // 32-bit instance signals
    logic        w32_valid, w32_ready, w32_o16, w32_last, w32_abort, w32_done, w32_error;
    logic [1:0]  w32_target;
    logic [31:0] w32_data;
    logic [31:0] w32_gdtr_base, w32_idtr_base, w32_ldtr_base, w32_ldtr_limit, w32_tr_base, w32_tr_limit;
    logic [15:0] w32_gdtr_limit, w32_idtr_limit, w32_ldtr_sel, w32_tr_sel;
    logic [7:0]  w32_ldtr_attr, w32_tr_attr;
    logic        w32_ldtr_valid, w32_tr_valid;

    // 16-bit instance signals
    logic        w16_valid, w16_ready, w16_o16, w16_last, w16_abort, w16_done, w16_error;
    logic [1:0]  w16_target;
    logic [15:0] w16_data;
    logic [31:0] w16_gdtr_base, w16_idtr_base, w16_ldtr_base, w16_ldtr_limit, w16_tr_base, w16_tr_limit;
    logic [15:0] w16_gdtr_limit, w16_idtr_limit, w16_ldtr_sel, w16_tr_sel;
    logic [7:0]  w16_ldtr_attr, w16_tr_attr;
    logic        w16_ldtr_valid, w16_tr_valid;

    system_table_registers #(.DATA_WIDTH(32), .SEL_WIDTH(16)) u_dut32 (
        .clock(clock), .reset(reset),
        .load_valid(w32_valid), .load_ready(w32_ready), .load_target(w32_target),
        .load_o16(w32_o16), .load_data(w32_data), .load_last(w32_last), .load_abort(w32_abort),
        .load_done(w32_done), .load_error(w32_error),
        .gdtr_base(w32_gdtr_base), .gdtr_limit(w32_gdtr_limit),
        .idtr_base(w32_idtr_base), .idtr_limit(w32_idtr_limit),
        .ldtr_sel(w32_ldtr_sel), .ldtr_base(w32_ldtr_base), .ldtr_limit(w32_ldtr_limit),
        .ldtr_attr(w32_ldtr_attr), .ldtr_valid(w32_ldtr_valid),
        .tr_sel(w32_tr_sel), .tr_base(w32_tr_base), .tr_limit(w32_tr_limit),
        .tr_attr(w32_tr_attr), .tr_valid(w32_tr_valid)
    );

    system_table_registers #(.DATA_WIDTH(16), .SEL_WIDTH(16)) u_dut16 (
        .clock(clock), .reset(reset),
        .load_valid(w16_valid), .load_ready(w16_ready), .load_target(w16_target),
        .load_o16(w16_o16), .load_data(w16_data), .load_last(w16_last), .load_abort(w16_abort),
        .load_done(w16_done), .load_error(w16_error),
        .gdtr_base(w16_gdtr_base), .gdtr_limit(w16_gdtr_limit),
        .idtr_base(w16_idtr_base), .idtr_limit(w16_idtr_limit),
        .ldtr_sel(w16_ldtr_sel), .ldtr_base(w16_ldtr_base), .ldtr_limit(w16_ldtr_limit),
        .ldtr_attr(w16_ldtr_attr), .ldtr_valid(w16_ldtr_valid),
        .tr_sel(w16_tr_sel), .tr_base(w16_tr_base), .tr_limit(w16_tr_limit),
        .tr_attr(w16_tr_attr), .tr_valid(w16_tr_valid)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one beat for a single cycle; returns at posedge+1 with the beat withdrawn.
    task automatic beat32(input logic [1:0] t, input logic o, input logic [31:0] d,
                          input logic l, input logic a);
        w32_valid = 1'b1; w32_target = t; w32_o16 = o; w32_data = d; w32_last = l; w32_abort = a;
        step();
        w32_valid = 1'b0; w32_last = 1'b0; w32_abort = 1'b0;
    endtask

    task automatic beat16(input logic [1:0] t, input logic o, input logic [15:0] d, input logic l);
        w16_valid = 1'b1; w16_target = t; w16_o16 = o; w16_data = d; w16_last = l; w16_abort = 1'b0;
        step();
        w16_valid = 1'b0; w16_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        if (w32_ready !== 1'b1) begin $display("FAIL rst_ready32: got %b want 1", w32_ready); n_fail++; end n_cmp++;
        if (w32_done !== 1'b0 || w32_error !== 1'b0) begin $display("FAIL rst_pulses32: got %b%b want 00", w32_done, w32_error); n_fail++; end n_cmp++;
        if (w32_gdtr_limit !== 16'hFFFF || w32_gdtr_base !== 32'h0) begin $display("FAIL rst_gdtr32: got %h/%h want 0/ffff", w32_gdtr_base, w32_gdtr_limit); n_fail++; end n_cmp++;
        if (w32_idtr_limit !== 16'h03FF || w32_idtr_base !== 32'h0) begin $display("FAIL rst_idtr32: got %h/%h want 0/03ff", w32_idtr_base, w32_idtr_limit); n_fail++; end n_cmp++;
        if (w32_ldtr_limit !== 32'h0000_FFFF || w32_ldtr_valid !== 1'b0 || w32_ldtr_sel !== 16'h0) begin $display("FAIL rst_ldtr32: got %h/%b/%h want 0000ffff/0/0000", w32_ldtr_limit, w32_ldtr_valid, w32_ldtr_sel); n_fail++; end n_cmp++;
        if (w32_tr_limit !== 32'h0000_FFFF || w32_tr_valid !== 1'b0 || w32_tr_attr !== 8'h0) begin $display("FAIL rst_tr32: got %h/%b/%h want 0000ffff/0/00", w32_tr_limit, w32_tr_valid, w32_tr_attr); n_fail++; end n_cmp++;
        if (w16_ready !== 1'b1 || w16_idtr_limit !== 16'h03FF) begin $display("FAIL rst_dut16: got ready %b idtr_limit %h want 1/03ff", w16_ready, w16_idtr_limit); n_fail++; end n_cmp++;
        reset = 1'b0;
    endtask

    task automatic test_gdtr_load();
        beat32(T_GDTR, 1'b0, 32'h5678_0027, 1'b0, 1'b0);
        if (w32_gdtr_limit !== 16'hFFFF || w32_done !== 1'b0) begin $display("FAIL gdtr_midload: got limit %h done %b want ffff/0", w32_gdtr_limit, w32_done); n_fail++; end n_cmp++;
        beat32(T_GDTR, 1'b0, 32'h0000_1234, 1'b1, 1'b0);
        if (w32_done !== 1'b1 || w32_error !== 1'b0) begin $display("FAIL gdtr_done: got done %b err %b want 1/0", w32_done, w32_error); n_fail++; end n_cmp++;
        if (w32_gdtr_limit !== 16'h0027) begin $display("FAIL gdtr_limit: got %h want 0027", w32_gdtr_limit); n_fail++; end n_cmp++;
        if (w32_gdtr_base !== 32'h1234_5678) begin $display("FAIL gdtr_base: got %h want 12345678", w32_gdtr_base); n_fail++; end n_cmp++;
        if (w32_ready !== 1'b0) begin $display("FAIL gdtr_ready_done: got %b want 0", w32_ready); n_fail++; end n_cmp++;
        step();
        if (w32_done !== 1'b0 || w32_ready !== 1'b1) begin $display("FAIL gdtr_after: got done %b ready %b want 0/1", w32_done, w32_ready); n_fail++; end n_cmp++;
    endtask

    task automatic test_idtr_o16();
        beat16(T_IDTR, 1'b1, 16'h07FF, 1'b0);
        beat16(T_IDTR, 1'b1, 16'h0000, 1'b0);
        beat16(T_IDTR, 1'b1, 16'hAB10, 1'b1);
        if (w16_done !== 1'b1) begin $display("FAIL idtr16_done: got %b want 1", w16_done); n_fail++; end n_cmp++;
        if (w16_idtr_base !== 32'h0010_0000) begin $display("FAIL idtr16_base: got %h want 00100000", w16_idtr_base); n_fail++; end n_cmp++;
        if (w16_idtr_limit !== 16'h07FF) begin $display("FAIL idtr16_limit: got %h want 07ff", w16_idtr_limit); n_fail++; end n_cmp++;
        step();
    endtask

    task automatic test_ldtr_desc();
        beat32(T_LDTR, 1'b0, 32'h0000_0028, 1'b0, 1'b0);
        beat32(T_LDTR, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
        beat32(T_LDTR, 1'b0, 32'h00CF_8200, 1'b1, 1'b0);
        if (w32_done !== 1'b1 || w32_ldtr_sel !== 16'h0028) begin $display("FAIL ldtr32_sel: got done %b sel %h want 1/0028", w32_done, w32_ldtr_sel); n_fail++; end n_cmp++;
        if (w32_ldtr_base !== 32'h0) begin $display("FAIL ldtr32_base: got %h want 00000000", w32_ldtr_base); n_fail++; end n_cmp++;
        if (w32_ldtr_limit !== 32'hFFFF_FFFF) begin $display("FAIL ldtr32_limit: got %h want ffffffff", w32_ldtr_limit); n_fail++; end n_cmp++;
        if (w32_ldtr_attr !== 8'h82 || w32_ldtr_valid !== 1'b1) begin $display("FAIL ldtr32_attr: got %h/%b want 82/1", w32_ldtr_attr, w32_ldtr_valid); n_fail++; end n_cmp++;
        step();
        beat16(T_LDTR, 1'b0, 16'h0028, 1'b0);
        beat16(T_LDTR, 1'b0, 16'hFFFF, 1'b0);
        beat16(T_LDTR, 1'b0, 16'h0000, 1'b0);
        beat16(T_LDTR, 1'b0, 16'h8200, 1'b0);
        beat16(T_LDTR, 1'b0, 16'h00CF, 1'b1);
        if (w16_done !== 1'b1 || w16_ldtr_limit !== 32'hFFFF_FFFF || w16_ldtr_attr !== 8'h82 || w16_ldtr_valid !== 1'b1) begin
            $display("FAIL ldtr16: got done %b limit %h attr %h valid %b want 1/ffffffff/82/1", w16_done, w16_ldtr_limit, w16_ldtr_attr, w16_ldtr_valid); n_fail++; end n_cmp++;
        step();
    endtask

    task automatic test_tr_desc();
        beat32(T_TR, 1'b0, 32'hABCD_0030, 1'b0, 1'b0);
        beat32(T_TR, 1'b0, 32'h1000_0067, 1'b0, 1'b0);
        beat32(T_TR, 1'b0, 32'h0040_8900, 1'b1, 1'b0);
        if (w32_tr_sel !== 16'h0030 || w32_tr_base !== 32'h0000_1000) begin $display("FAIL tr_sel_base: got %h/%h want 0030/00001000", w32_tr_sel, w32_tr_base); n_fail++; end n_cmp++;
        if (w32_tr_limit !== 32'h0000_0067 || w32_tr_attr !== 8'h89 || w32_tr_valid !== 1'b1) begin $display("FAIL tr_limit_attr: got %h/%h/%b want 00000067/89/1", w32_tr_limit, w32_tr_attr, w32_tr_valid); n_fail++; end n_cmp++;
        step();
    endtask

    task automatic test_null_selector();
        beat32(T_LDTR, 1'b0, 32'h0000_0003, 1'b1, 1'b0);
        if (w32_done !== 1'b1 || w32_error !== 1'b0) begin $display("FAIL ldtr_null_done: got %b%b want 10", w32_done, w32_error); n_fail++; end n_cmp++;
        if (w32_ldtr_sel !== 16'h0003 || w32_ldtr_valid !== 1'b0) begin $display("FAIL ldtr_null_sel: got %h/%b want 0003/0", w32_ldtr_sel, w32_ldtr_valid); n_fail++; end n_cmp++;
        if (w32_ldtr_limit !== 32'hFFFF_FFFF || w32_ldtr_attr !== 8'h82) begin $display("FAIL ldtr_null_keep: got %h/%h want ffffffff/82", w32_ldtr_limit, w32_ldtr_attr); n_fail++; end n_cmp++;
        step();
        beat32(T_TR, 1'b0, 32'hFFFF_0000, 1'b1, 1'b0);
        if (w32_error !== 1'b1 || w32_done !== 1'b0) begin $display("FAIL tr_null_err: got err %b done %b want 1/0", w32_error, w32_done); n_fail++; end n_cmp++;
        if (w32_tr_sel !== 16'h0030 || w32_tr_valid !== 1'b1 || w32_tr_base !== 32'h0000_1000) begin $display("FAIL tr_null_keep: got %h/%b/%h want 0030/1/00001000", w32_tr_sel, w32_tr_valid, w32_tr_base); n_fail++; end n_cmp++;
        step();
    endtask

    task automatic test_framing();
        beat32(T_GDTR, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        if (w32_error !== 1'b1 || w32_done !== 1'b0) begin $display("FAIL early_last_err: got err %b done %b want 1/0", w32_error, w32_done); n_fail++; end n_cmp++;
        if (w32_gdtr_base !== 32'h1234_5678 || w32_gdtr_limit !== 16'h0027) begin $display("FAIL early_last_keep: got %h/%h want 12345678/0027", w32_gdtr_base, w32_gdtr_limit); n_fail++; end n_cmp++;
        step();
        beat32(T_GDTR, 1'b0, 32'h1111_2222, 1'b0, 1'b0);
        beat32(T_GDTR, 1'b0, 32'h3333_4444, 1'b0, 1'b0);
        if (w32_error !== 1'b1 || w32_gdtr_base !== 32'h1234_5678) begin $display("FAIL missing_last: got err %b base %h want 1/12345678", w32_error, w32_gdtr_base); n_fail++; end n_cmp++;
        step();
    endtask

    task automatic test_abort();
        beat32(T_GDTR, 1'b0, 32'h9999_8888, 1'b0, 1'b0);
        beat32(T_GDTR, 1'b0, 32'h7777_6666, 1'b1, 1'b1);
        if (w32_done !== 1'b0 || w32_error !== 1'b0 || w32_ready !== 1'b1) begin $display("FAIL abort_pulses: got done %b err %b ready %b want 0/0/1", w32_done, w32_error, w32_ready); n_fail++; end n_cmp++;
        if (w32_gdtr_base !== 32'h1234_5678 || w32_gdtr_limit !== 16'h0027) begin $display("FAIL abort_keep: got %h/%h want 12345678/0027", w32_gdtr_base, w32_gdtr_limit); n_fail++; end n_cmp++;
    endtask

    task automatic test_back_to_back();
        // Abort with the first beat is ignored; target/o16 changes on beat 2 must not matter.
        beat32(T_GDTR, 1'b0, 32'hBEEF_01FF, 1'b0, 1'b1);
        beat32(T_IDTR, 1'b1, 32'h0000_CAFE, 1'b1, 1'b0);
        if (w32_done !== 1'b1) begin $display("FAIL b2b_done: got %b want 1", w32_done); n_fail++; end n_cmp++;
        if (w32_gdtr_base !== 32'hCAFE_BEEF || w32_gdtr_limit !== 16'h01FF) begin $display("FAIL b2b_gdtr: got %h/%h want cafebeef/01ff", w32_gdtr_base, w32_gdtr_limit); n_fail++; end n_cmp++;
        if (w32_idtr_base !== 32'h0 || w32_idtr_limit !== 16'h03FF) begin $display("FAIL b2b_idtr: got %h/%h want 0/03ff", w32_idtr_base, w32_idtr_limit); n_fail++; end n_cmp++;
        step();
    endtask

    task automatic test_reset_mid();
        beat32(T_TR, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
        beat32(T_TR, 1'b0, 32'h1000_0067, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        if (w32_done !== 1'b0 || w32_error !== 1'b0) begin $display("FAIL rmid_pulses: got %b%b want 00", w32_done, w32_error); n_fail++; end n_cmp++;
        if (w32_gdtr_base !== 32'h0 || w32_gdtr_limit !== 16'hFFFF) begin $display("FAIL rmid_gdtr: got %h/%h want 0/ffff", w32_gdtr_base, w32_gdtr_limit); n_fail++; end n_cmp++;
        if (w32_ldtr_limit !== 32'h0000_FFFF || w32_ldtr_valid !== 1'b0 || w32_ldtr_attr !== 8'h0) begin $display("FAIL rmid_ldtr: got %h/%b/%h want 0000ffff/0/00", w32_ldtr_limit, w32_ldtr_valid, w32_ldtr_attr); n_fail++; end n_cmp++;
        if (w32_tr_sel !== 16'h0 || w32_tr_valid !== 1'b0 || w32_tr_base !== 32'h0) begin $display("FAIL rmid_tr: got %h/%b/%h want 0/0/0", w32_tr_sel, w32_tr_valid, w32_tr_base); n_fail++; end n_cmp++;
        reset = 1'b0;
        if (w32_ready !== 1'b1) begin $display("FAIL rmid_ready: got %b want 1", w32_ready); n_fail++; end n_cmp++;
        // The old third beat now starts a fresh TR load and ends it early.
        beat32(T_TR, 1'b0, 32'h0040_8900, 1'b1, 1'b0);
        if (w32_error !== 1'b1 || w32_tr_valid !== 1'b0) begin $display("FAIL rmid_discard: got err %b valid %b want 1/0", w32_error, w32_tr_valid); n_fail++; end n_cmp++;
        step();
    endtask

    initial begin
        reset = 1'b1;
        w32_valid = 1'b0; w32_target = 2'd0; w32_o16 = 1'b0; w32_data = '0; w32_last = 1'b0; w32_abort = 1'b0;
        w16_valid = 1'b0; w16_target = 2'd0; w16_o16 = 1'b0; w16_data = '0; w16_last = 1'b0; w16_abort = 1'b0;
        test_reset();
        test_gdtr_load();
        test_idtr_o16();
        test_ldtr_desc();
        test_tr_desc();
        test_null_selector();
        test_framing();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/system_table_registers.md
SYSTEM_TABLE_REGISTERS -- requirements
Module: system_table_registers

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, load beat width; legal values 16 or 32.
REQ-002 SHALL have parameter SEL_WIDTH, default 16, selector width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  beat offered.
REQ-006 SHALL have port load_ready  output  1  beat can be accepted.
REQ-007 SHALL have port load_target  input  2  0=GDTR, 1=IDTR, 2=LDTR, 3=TR; sampled on first beat only.
REQ-008 SHALL have port load_o16  input  1  16-bit operand size; sampled on first beat only.
REQ-009 SHALL have port load_data  input  DATA_WIDTH  beat payload, little-endian byte order.
REQ-010 SHALL have port load_last  input  1  requester marks final beat.
REQ-011 SHALL have port load_abort  input  1  cancel the transaction in progress.
REQ-012 SHALL have port load_done  output  1  one-cycle commit pulse.
REQ-013 SHALL have port load_error  output  1  one-cycle framing-error pulse.
REQ-014 SHALL have ports gdtr_base and idtr_base  output  32, and gdtr_limit and idtr_limit  output  16.
REQ-015 SHALL have ports ldtr_sel and tr_sel  output  SEL_WIDTH; ldtr_base and tr_base  output  32; ldtr_limit and tr_limit  output  32; ldtr_attr and tr_attr  output  8; ldtr_valid and tr_valid  output  1.

Function
REQ-016 Beat handshake: a beat SHALL be accepted on a rising edge where load_valid && load_ready.
REQ-017 FSM states SHALL be IDLE, COLLECT and DONE; load_ready=1 in IDLE and COLLECT, 0 in DONE.
REQ-018 State transitions SHALL be:
  - IDLE->COLLECT on the first accepted beat.
  - COLLECT->DONE on the final accepted beat.
  - DONE->IDLE unconditionally after one cycle.
REQ-019 The first accepted beat SHALL latch load_target and load_o16, and each accepted beat SHALL shift into a 96-bit assembly buffer indexed by a beat counter.
REQ-020 The payload of a GDTR/IDTR load SHALL be 48 bits: limit[15:0], then base[31:0].
REQ-021 The payload of an LDTR/TR load SHALL be a selector (low 16 bits of beat 0; the upper bits of beat 0 are ignored), followed by a 64-bit descriptor.
REQ-022 Required beat counts SHALL be:
  - GDTR/IDTR: 3 beats at DATA_WIDTH=16, 2 beats at DATA_WIDTH=32.
  - LDTR/TR: 5 beats at DATA_WIDTH=16, 3 beats at DATA_WIDTH=32.
REQ-023 Null-selector case: if target is LDTR and selector[15:2]==0, the load SHALL be a single beat; commit sets ldtr_sel and ldtr_valid=0 and leaves base/limit/attr unchanged.
REQ-024 If target is TR and selector[15:2]==0, the transaction SHALL complete as a single beat with load_error=1 and no register change.
REQ-025 Descriptor unpack SHALL be:
  - base = {d[63:56], d[39:16]}
  - raw limit = {d[51:48], d[15:0]}
  - attr = d[47:40]
  - if G=d[55] is set, limit = {raw, 12'hFFF}; otherwise limit = zero-extended raw.
REQ-026 If load_o16=1 on a GDTR/IDTR load, the committed base[31:24] SHALL be forced to 0.
REQ-027 Outputs SHALL change only at commit, atomically, on the edge that moves the FSM to DONE; load_done SHALL be 1 during DONE.
REQ-028 Latency from acceptance of the final beat to updated outputs SHALL be 1 clock.
REQ-029 On a framing error (load_last=1 before the required count, or load_last=0 on the required final beat):
  - the FSM SHALL go to DONE;
  - load_error SHALL be 1 (instead of load_done) in DONE;
  - no register SHALL change.
REQ-030 load_abort in COLLECT SHALL return the FSM to IDLE next cycle with no change and no pulses; abort SHALL win over a simultaneous beat.
REQ-031 load_abort in IDLE SHALL be ignored, and any beat offered with it SHALL be accepted normally.
REQ-032 Changes to load_target or load_o16 after the first beat SHALL have no effect.
REQ-033 Committing LDTR/TR with a non-null selector SHALL set the corresponding valid flag to 1.

Reset
REQ-034 Reset SHALL apply the following:
  - FSM=IDLE, beat counter=0, buffer=0, load_done=0, load_error=0.
  - gdtr_base=0, gdtr_limit=16'hFFFF.
  - idtr_base=0, idtr_limit=16'h03FF.
  - LDTR/TR: sel=0, base=0, limit=32'h0000FFFF, attr=0, valid=0.
REQ-035 Reset asserted mid-transaction SHALL discard all collected beats without commit or pulse.
REQ-036 load_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-037 Shared package system_register_pkg SHALL hold:
  - the target enum (GDTR, IDTR, LDTR, TR);
  - the table_reg_t struct (base, limit);
  - the seg_reg_t struct (sel, base, limit, attr, valid);
  - all reset-value constants.
REQ-038 Descriptor unpacking (REQ-025) SHALL be a combinational sub-module named descriptor_unpack.
REQ-039 Beat-count lookup SHALL be a package function of target, DATA_WIDTH and null-selector.

Verification
REQ-040 Bench SHALL cover: DATA_WIDTH=32, GDTR beats 0x5678_0027, 0x0000_1234 with last on beat 2 -> gdtr_limit=0x0027, gdtr_base=0x1234_5678, done pulse.
REQ-041 Bench SHALL cover: DATA_WIDTH=16, IDTR with o16=1, beats 0x07FF, 0x0000, 0xAB10 -> idtr_base=0x0010_0000, idtr_limit=0x07FF.
REQ-042 Bench SHALL cover: LDTR selector 0x0028, descriptor 0x00CF_8200_0000_FFFF -> ldtr_base=0, ldtr_limit=0xFFFF_FFFF, ldtr_attr=0x82, ldtr_valid=1.
REQ-043 Bench SHALL cover: LDTR selector 0x0003 single beat -> ldtr_sel=0x0003, ldtr_valid=0; TR selector 0x0000 -> load_error=1, TR unchanged.
REQ-044 Bench SHALL cover: GDTR with load_last on beat 1 at DATA_WIDTH=32 -> load_error=1, gdtr unchanged; abort concurrent with final beat -> no pulse, no change.
REQ-045 Bench SHALL cover: reset asserted after 2 TR beats -> all outputs at REQ-034 values, load_ready=1 next cycle.
